mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, the data requester and the shared memory
//   port seen by mem_port_arbiter.
//   slave  : the arbiter side (takes requests, drives done/rdata/stalls and
//            the memory port fields).
//   master : the surrounding pipeline and memory model.
//   Fetch  : if_req, if_addr, flush -> if_done, if_rdata[31:0], if_stall
//   Data   : d_req, d_we, d_addr, d_wdata, d_funct3 -> d_done, d_rdata, mem_stall
//   Memory : mem_req, mem_we, mem_addr, mem_wdata, mem_funct3 <- mem_ready, mem_rdata
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              if_stall;
  logic              mem_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, flush,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    input  mem_ready, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata,
    output if_stall, mem_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
  );

  modport master (
    output if_req, if_addr, flush,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    output mem_ready, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata,
    input  if_stall, mem_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_funct3
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction fetch and the data
//   (load/store) requester. Data normally has priority; a fetch that keeps
//   losing ties is forced through after STARVE_MAX consecutive data grants.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous reset, active low
//     bus   : mem_port_arbiter_if.slave (requesters + memory port)
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              flushed_q, flushed_d;

  logic              if_elig, d_elig, starve_sat;
  logic              grant_if, grant_d;

  // Arbitration. A requester still holding its request during its own done
  // cycle must not be regranted, and a fetch is never granted in a flush
  // cycle because its PC is about to be replaced.
  always_comb begin
    if_elig    = bus.if_req & ~if_done_q & ~bus.flush;
    d_elig     = bus.d_req & ~d_done_q;
    starve_sat = (starve_cnt_q == CNT_MAX);
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    if (state_q == IDLE) begin
      if (if_elig && d_elig) begin
        grant_if = starve_sat;
        grant_d  = ~starve_sat;
      end else if (if_elig) begin
        grant_if = 1'b1;
      end else if (d_elig) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    flushed_d  = flushed_q;

    case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        if (grant_if) begin
          state_d  = BUSY_IF;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          funct3_d = FETCH_FUNCT3;
        end else if (grant_d) begin
          state_d  = BUSY_D;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          we_d     = bus.d_we;
          funct3_d = bus.d_funct3;
        end
      end
      BUSY_IF: begin
        // A flush seen at any point of the fetch (including its final cycle)
        // lets the memory access finish but drops the result; if_rdata keeps
        // the last delivered instruction.
        if (bus.flush) flushed_d = 1'b1;
        if (bus.mem_ready) begin
          state_d   = IDLE;
          flushed_d = 1'b0;
          if (!(flushed_q || bus.flush)) begin
            if_rdata_d = bus.mem_rdata[31:0];
            if_done_d  = 1'b1;
          end
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          d_rdata_d = bus.mem_rdata;
          d_done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_d && !starve_sat) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      flushed_q    <= flushed_d;
    end
  end

  // mem_req is decoded from the state register so an asynchronous reset
  // drops it in the same cycle.
  assign bus.mem_req    = (state_q != IDLE);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_funct3 = funct3_q;

  assign bus.if_done    = if_done_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_done     = d_done_q;
  assign bus.d_rdata    = d_rdata_q;

  assign bus.if_stall   = bus.if_req & ~if_done_q;
  assign bus.mem_stall  = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk;
  logic reset;

  int checks;
  int errors;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic        fl;
    logic        dr;
    logic        dw;
    logic        mr;
    logic [31:0] rd;
    logic        e_mreq;
    logic        e_we;
    logic [2:0]  e_f3;
    logic [63:0] e_addr;
    logic        e_idone;
    logic        e_ddone;
    logic        e_istall;
    logic        e_mstall;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    //          ir fl dr dw mr rd             mreq we f3    addr     idone ddone istall mstall
    vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 3'd0, 64'h0,   0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 32'h1,        0, 0, 3'd0, 64'h0,   0, 0, 1, 0};
    vecs[2]  = '{1, 0, 0, 0, 1, 32'h11111111, 1, 0, 3'd2, 64'h10,  0, 0, 1, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 32'h3,        0, 0, 3'd0, 64'h0,   1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 32'h4,        0, 0, 3'd0, 64'h0,   0, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 1, 0, 32'h5,        0, 0, 3'd0, 64'h0,   0, 0, 1, 1};
    vecs[6]  = '{1, 0, 1, 1, 1, 32'h66,       1, 1, 3'd3, 64'h40,  0, 0, 1, 1};
    vecs[7]  = '{1, 0, 1, 1, 0, 32'h7,        0, 0, 3'd0, 64'h0,   0, 1, 1, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 32'h8,        1, 0, 3'd2, 64'h10,  0, 0, 1, 0};
    vecs[9]  = '{1, 0, 0, 0, 1, 32'h99,       1, 0, 3'd2, 64'h10,  0, 0, 1, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 32'hA,        0, 0, 3'd0, 64'h0,   1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 32'hB,        0, 0, 3'd0, 64'h0,   0, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 0, 32'hC,        0, 0, 3'd0, 64'h0,   0, 0, 0, 1};
    vecs[13] = '{0, 0, 1, 0, 1, 32'hDD,       1, 0, 3'd3, 64'h40,  0, 0, 0, 1};
    vecs[14] = '{0, 0, 1, 0, 0, 32'hE,        0, 0, 3'd0, 64'h0,   0, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 3'd0, 64'h0,   0, 0, 0, 0};

    reset          = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = 64'h10;
    bus.flush      = 1'b0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 64'h40;
    bus.d_wdata    = 64'hAB;
    bus.d_funct3   = 3'b011;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;

    repeat (3) @(posedge clk);
    smp();
    chk("rst_mem_req",  bus.mem_req, 0);
    chk("rst_mem_we",   bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_done",  bus.if_done, 0);
    chk("rst_d_done",   bus.d_done, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata",  bus.d_rdata, 0);
    reset = 1'b1;

    // Table: single fetch, simultaneous data+fetch, single load.
    for (int i = 0; i < 16; i++) begin
      adv();
      bus.if_req    = vecs[i].ir;
      bus.flush     = vecs[i].fl;
      bus.d_req     = vecs[i].dr;
      bus.d_we      = vecs[i].dw;
      bus.mem_ready = vecs[i].mr;
      bus.mem_rdata = {~vecs[i].rd, vecs[i].rd};
      smp();
      chk($sformatf("v%0d_mem_req", i),   bus.mem_req,   vecs[i].e_mreq);
      chk($sformatf("v%0d_if_done", i),   bus.if_done,   vecs[i].e_idone);
      chk($sformatf("v%0d_d_done", i),    bus.d_done,    vecs[i].e_ddone);
      chk($sformatf("v%0d_if_stall", i),  bus.if_stall,  vecs[i].e_istall);
      chk($sformatf("v%0d_mem_stall", i), bus.mem_stall, vecs[i].e_mstall);
      if (vecs[i].e_mreq) begin
        chk($sformatf("v%0d_mem_we", i),     bus.mem_we,     vecs[i].e_we);
        chk($sformatf("v%0d_mem_funct3", i), bus.mem_funct3, vecs[i].e_f3);
        chk($sformatf("v%0d_mem_addr", i),   bus.mem_addr,   vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, 64'hAB);
      end
      if (vecs[i].e_idone && i > 0)
        chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, vecs[i-1].rd);
      if (vecs[i].e_ddone && i > 0)
        chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, {~vecs[i-1].rd, vecs[i-1].rd});
    end

    // Starvation: fetch pending across four data grants. Flush is raised in
    // each d_done cycle so the fetch cannot slip in there; the fifth grant
    // must then go to the fetch.
    adv();
    bus.if_req = 1; bus.d_req = 1; bus.d_we = 1; bus.mem_ready = 1; bus.flush = 0;
    bus.mem_rdata = 64'h0000_0000_C0DE_0001;
    smp();
    for (int k = 0; k < 4; k++) begin
      adv(); smp();
      chk($sformatf("starve%0d_dgrant_req", k), bus.mem_req, 1);
      chk($sformatf("starve%0d_dgrant_we", k),  bus.mem_we, 1);
      adv(); bus.flush = 1; smp();
      chk($sformatf("starve%0d_d_done", k), bus.d_done, 1);
      chk($sformatf("starve%0d_cnt", k),    dut.starve_cnt_q, 64'(k + 1));
      adv(); bus.flush = 0; smp();
    end
    adv(); smp();
    chk("starve_fetch_req",  bus.mem_req, 1);
    chk("starve_fetch_we",   bus.mem_we, 0);
    chk("starve_fetch_addr", bus.mem_addr, 64'h10);
    chk("starve_cnt_clear",  dut.starve_cnt_q, 0);
    adv(); bus.if_req = 0; bus.d_req = 0; bus.mem_ready = 0; smp();
    chk("starve_if_done",  bus.if_done, 1);
    chk("starve_if_rdata", bus.if_rdata, 64'hC0DE_0001);

    // Flush during BUSY_IF, memory ready only in the third mem_req cycle.
    adv(); bus.if_req = 1; smp();
    adv(); bus.flush = 1; smp();
    chk("flush_mreq1", bus.mem_req, 1);
    adv(); bus.flush = 0; smp();
    chk("flush_mreq2", bus.mem_req, 1);
    chk("flush_nodone2", bus.if_done, 0);
    adv(); bus.mem_ready = 1; bus.mem_rdata = 64'h5555_5555_BAD0_BAD0; smp();
    chk("flush_mreq3", bus.mem_req, 1);
    adv(); bus.mem_ready = 0; bus.if_addr = 64'h20; smp();
    chk("flush_mreq_drop", bus.mem_req, 0);
    chk("flush_nodone",    bus.if_done, 0);
    chk("flush_rdata_hold", bus.if_rdata, 64'hC0DE_0001);
    adv(); bus.mem_ready = 1; bus.mem_rdata = 64'h0000_0000_F00D_0020; smp();
    chk("flush_next_req",  bus.mem_req, 1);
    chk("flush_next_addr", bus.mem_addr, 64'h20);
    adv(); bus.mem_ready = 0; bus.if_req = 0; smp();
    chk("flush_next_done",  bus.if_done, 1);
    chk("flush_next_rdata", bus.if_rdata, 64'hF00D_0020);

    // Flush in the completing cycle of a fetch.
    adv(); bus.if_req = 1; smp();
    adv(); bus.mem_ready = 1; bus.flush = 1; bus.mem_rdata = 64'h0000_0000_BAD1_BAD1; smp();
    chk("flushlast_mreq", bus.mem_req, 1);
    adv(); bus.mem_ready = 0; bus.flush = 0; bus.if_req = 0; smp();
    chk("flushlast_nodone", bus.if_done, 0);
    chk("flushlast_rdata",  bus.if_rdata, 64'hF00D_0020);

    // Flush in IDLE does not block a data grant.
    adv(); bus.flush = 1; bus.d_req = 1; bus.d_we = 0; smp();
    adv(); bus.flush = 0; bus.mem_ready = 1; bus.mem_rdata = 64'h1234_5678_9ABC_DEF0; smp();
    chk("flushidle_dreq",  bus.mem_req, 1);
    chk("flushidle_daddr", bus.mem_addr, 64'h40);
    adv(); bus.d_req = 0; bus.mem_ready = 0; smp();
    chk("flushidle_ddone", bus.d_done, 1);
    chk("flushidle_drdata", bus.d_rdata, 64'h1234_5678_9ABC_DEF0);

    // Reset in the middle of a data access.
    adv(); bus.if_req = 1; bus.d_req = 1; bus.d_we = 1; bus.mem_ready = 0; smp();
    adv(); smp();
    chk("rstmid_mreq_before",  bus.mem_req, 1);
    chk("rstmid_cnt_before",   dut.starve_cnt_q, 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_mreq_async",  bus.mem_req, 0);
    chk("rstmid_addr_async",  bus.mem_addr, 0);
    chk("rstmid_we_async",    bus.mem_we, 0);
    bus.if_req = 0; bus.d_req = 0;
    adv(); smp();
    chk("rstmid_nodone", bus.d_done, 0);
    reset = 1'b1;
    adv(); smp();
    chk("rstmid_state_idle", dut.state_q, 0);
    chk("rstmid_cnt_zero",   dut.starve_cnt_q, 0);
    chk("rstmid_mreq_after", bus.mem_req, 0);
    chk("rstmid_nodone_after", bus.d_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
